// File: rtl/rxblock_if.sv
// ----------------------------------------------------------------------------
// rxblock_if
//
// Groups the serial line input and the received-byte outputs of the UART
// receiver into one bundle. The clock (clk16) and reset (rst_n) are plain
// ports on rxblock and are not part of this interface.
//
// Signals:
//   serial_data  line -> receiver  asynchronous serial input, idles high
//   rx_en        user -> receiver  enables detection of new start bits
//   paral_data   receiver -> user  last good received byte (8 bits)
//   rx_end       receiver -> user  one-cycle strobe at the end of each frame
//   frame_err    receiver -> user  stop bit of the last frame sampled low
//   parity_err   receiver -> user  parity error on the last frame
//   rx_busy      receiver -> user  high while a frame is being received
//
// Modports:
//   slave   the receiver itself (rxblock)
//   master  whatever drives the line and consumes the bytes
// ----------------------------------------------------------------------------
interface rxblock_if;

    logic       serial_data;
    logic       rx_en;
    logic [7:0] paral_data;
    logic       rx_end;
    logic       frame_err;
    logic       parity_err;
    logic       rx_busy;

    modport slave (
        input  serial_data,
        input  rx_en,
        output paral_data,
        output rx_end,
        output frame_err,
        output parity_err,
        output rx_busy
    );

    modport master (
        output serial_data,
        output rx_en,
        input  paral_data,
        input  rx_end,
        input  frame_err,
        input  parity_err,
        input  rx_busy
    );

endinterface

// File: rtl/rxblock.sv
// ----------------------------------------------------------------------------
// rxblock
//
// UART receiver, 16x oversampled. Rebuilds 8N1 frames (1 start bit, 8 data
// bits LSB first, 1 stop bit) from the serial line and presents each byte on
// paral_data with a one-cycle rx_end strobe and a framing-error flag.
//
// Build option:
//   RXBLOCK_PARITY_EN  when defined the frame is 8E1: an even parity bit sits
//                      between the data bits and the stop bit, and parity_err
//                      reports a mismatch. When undefined parity_err is tied
//                      to 0. Must match the txblock build on the same link.
//
// Ports:
//   clk16   16x baud clock, the only clock
//   rst_n   asynchronous active-low reset
//   bus     rxblock_if.slave: serial_data, rx_en in; paral_data, rx_end,
//           frame_err, parity_err, rx_busy out (all outputs registered)
// ----------------------------------------------------------------------------
module rxblock (
    input  logic      clk16,
    input  logic      rst_n,
    rxblock_if.slave  bus
);

`ifdef RXBLOCK_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;
`endif

    state_t     state;
    state_t     next_state;

    // two-flop synchronizer plus one history flop for edge detection
    logic       rxd_m;
    logic       rxd_s;
    logic       rxd_d;

    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic [2:0] bitcnt;
    logic [2:0] bitcnt_next;

    logic [7:0] shreg;
    logic       shift_en;
    logic       stop_en;

    logic [7:0] paral_data_q;
    logic       rx_end_q;
    logic       frame_err_q;
    logic       rx_busy_q;

`ifdef RXBLOCK_PARITY_EN
    logic       par_en;
    logic       par_bit;
    logic       parity_err_q;
`endif

    // The serial line is asynchronous to clk16, so it passes through two
    // flops before anything looks at it. rxd_d keeps the previous
    // synchronized value so IDLE can detect a genuine high-to-low edge; a
    // line that is merely held low never looks like a new start bit. All
    // three reset to the idle-line level so a reset never fakes an edge.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= bus.serial_data;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    // State register together with the two counters the FSM steers. The
    // counters are updated from values computed in the next-state logic so
    // every transition decides the counter behaviour in one place.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            bitcnt <= 3'd0;
        end else begin
            state  <= next_state;
            cnt    <= cnt_next;
            bitcnt <= bitcnt_next;
        end
    end

    // Next-state and control decode. cnt free-runs and wraps 15 -> 0 inside a
    // frame, so after the start check clears it at mid-start-bit every later
    // cnt==15 lands on the middle of the following bit. Sampling the stop bit
    // at its middle returns the FSM to IDLE half a bit early, which leaves
    // time to catch a back-to-back start edge. rx_en only gates the IDLE exit,
    // so a frame already under way always completes.
    always_comb begin
        next_state  = state;
        cnt_next    = cnt + 4'd1;
        bitcnt_next = bitcnt;
        shift_en    = 1'b0;
        stop_en     = 1'b0;
`ifdef RXBLOCK_PARITY_EN
        par_en      = 1'b0;
`endif

        case (state)
            IDLE: begin
                cnt_next = 4'd0;
                if (bus.rx_en && rxd_d && !rxd_s) begin
                    next_state = START;
                end
            end

            START: begin
                if (cnt == 4'd7) begin
                    cnt_next = 4'd0;
                    if (!rxd_s) begin
                        next_state  = DATA;
                        bitcnt_next = 3'd0;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end

            DATA: begin
                if (cnt == 4'd15) begin
                    shift_en    = 1'b1;
                    bitcnt_next = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
`ifdef RXBLOCK_PARITY_EN
                        next_state = PARITY;
`else
                        next_state = STOP;
`endif
                    end
                end
            end

`ifdef RXBLOCK_PARITY_EN
            PARITY: begin
                if (cnt == 4'd15) begin
                    par_en     = 1'b1;
                    next_state = STOP;
                end
            end
`endif

            STOP: begin
                if (cnt == 4'd15) begin
                    stop_en    = 1'b1;
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Receive shift register. Bits enter at the MSB and move right, so after
    // eight samples the first (least significant) bit sits in bit 0.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= 8'h00;
        end else if (shift_en) begin
            shreg <= {rxd_s, shreg[7:1]};
        end
    end

`ifdef RXBLOCK_PARITY_EN
    // Captured parity bit, checked only once the stop bit proves the frame
    // was well formed.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            par_bit <= 1'b0;
        end else if (par_en) begin
            par_bit <= rxd_s;
        end
    end
`endif

    // Result registers. They all change on the stop-bit sample, so rx_end,
    // paral_data and the error flags become visible together, and the flags
    // then hold until the next frame ends. A frame with a low stop bit is not
    // trusted: paral_data keeps the previous good byte and only frame_err is
    // raised. rx_busy follows the upcoming state so it drops in the same
    // cycle that rx_end is high.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            paral_data_q <= 8'h00;
            rx_end_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
`ifdef RXBLOCK_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_end_q  <= stop_en;
            rx_busy_q <= (next_state != IDLE);
            if (stop_en) begin
                if (rxd_s) begin
                    paral_data_q <= shreg;
                    frame_err_q  <= 1'b0;
`ifdef RXBLOCK_PARITY_EN
                    parity_err_q <= ^{shreg, par_bit};
`endif
                end else begin
                    frame_err_q  <= 1'b1;
`ifdef RXBLOCK_PARITY_EN
                    parity_err_q <= 1'b0;
`endif
                end
            end
        end
    end

    assign bus.paral_data = paral_data_q;
    assign bus.rx_end     = rx_end_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.rx_busy    = rx_busy_q;
`ifdef RXBLOCK_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_rxblock.sv
// ----------------------------------------------------------------------------
// tb_rxblock
//
// Self-checking bench for rxblock. Frames are driven bit by bit on the serial
// line (16 clk16 cycles per bit); a monitor records every rx_end pulse with
// its cycle number and the outputs seen in that cycle. Expected results come
// from a constant vector table, hand-written corner-case sequences, and a
// frame-level reference model for randomized traffic.
// ----------------------------------------------------------------------------
module tb_rxblock;

`ifdef RXBLOCK_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    // The line is driven right after a falling edge at cycle N; two
    // synchronizer flops put it on rxd_s after edge N+2, so IDLE sees it at
    // T = N+3. The stop sample is T+152 (T+168 with parity) and rx_end is
    // visible in the cycle after that edge.
    localparam int STROBE_LAT = PAR_EN ? 171 : 155;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       ferr;
        logic       perr;
        logic       busy;
    } evt_t;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       par_flip;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    logic clk16 = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks   = 0;
    int   failures = 0;
    evt_t evq[$];

    rxblock_if bus();

    rxblock dut (
        .clk16 (clk16),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 100 MHz stand-in for the 16x baud clock
    always #5 clk16 = ~clk16;

    // cycle index used to time-stamp strobes
    always @(posedge clk16) cyc <= cyc + 1;

    // record every end-of-frame strobe with the outputs of that cycle
    always @(negedge clk16) begin
        if (bus.rx_end === 1'b1) begin
            evq.push_back('{cyc, bus.paral_data, bus.frame_err, bus.parity_err, bus.rx_busy});
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic drive_bit(input logic b);
        bus.serial_data = b;
        repeat (16) @(negedge clk16);
    endtask

    // Sends one frame starting at the current falling edge, then gap_bits of
    // idle-high line. start_cyc returns the cycle the start bit began.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic par_flip,
                                 input int gap_bits, output int start_cyc);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        if (PAR_EN) drive_bit((^data) ^ par_flip);
        drive_bit(stop_bit);
        for (int i = 0; i < gap_bits; i++) drive_bit(1'b1);
    endtask

    // Exactly one strobe is expected since the queue was last emptied.
    task automatic expectFrame(input string name, input int start_cyc, input logic [7:0] d,
                               input logic ferr, input logic perr);
        evt_t e;
        checkOutput({name, ".count"}, evq.size(), 1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            checkOutput({name, ".cycle"}, e.cyc, start_cyc + STROBE_LAT);
            checkOutput({name, ".data"},  e.data, d);
            checkOutput({name, ".ferr"},  e.ferr, ferr);
            checkOutput({name, ".perr"},  e.perr, perr);
            checkOutput({name, ".busy"},  e.busy, 1'b0);
        end
        checkOutput({name, ".hold"}, bus.paral_data, d);
        evq.delete();
    endtask

    // Frame-level reference: a valid stop bit delivers the byte and the even
    // parity verdict; a low stop bit keeps the old byte and flags framing.
    function automatic void model_frame(input logic [7:0] d, input logic stop_bit, input logic pbit,
                                        inout logic [7:0] last_good, output logic ferr, output logic perr);
        if (stop_bit) begin
            last_good = d;
            ferr      = 1'b0;
            perr      = PAR_EN ? ^{d, pbit} : 1'b0;
        end else begin
            ferr = 1'b1;
            perr = 1'b0;
        end
    endfunction

    initial begin
        vec_t       vecs[8];
        int         st;
        int         st2;
        logic [7:0] last_good;
        logic       eferr;
        logic       eperr;

        vecs[0] = '{8'h8E, 1'b1, 1'b0, 8'h8E, 1'b0, 1'b0};
        vecs[1] = '{8'h55, 1'b0, 1'b0, 8'h8E, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[3] = '{8'h8E, 1'b1, 1'b1, 8'h8E, 1'b0, 1'b1};
        vecs[4] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};

        // reset with the line idle
        bus.serial_data = 1'b1;
        bus.rx_en       = 1'b0;
        #2 rst_n = 1'b0;
        #39;
        checkOutput("reset.paral_data", bus.paral_data, 8'h00);
        checkOutput("reset.rx_end",     bus.rx_end,     1'b0);
        checkOutput("reset.frame_err",  bus.frame_err,  1'b0);
        checkOutput("reset.parity_err", bus.parity_err, 1'b0);
        checkOutput("reset.rx_busy",    bus.rx_busy,    1'b0);
        #1 rst_n = 1'b1;
        @(negedge clk16);
        bus.rx_en = 1'b1;
        repeat (1000) @(negedge clk16);
        checkOutput("reset.no_strobe", evq.size(), 0);
        checkOutput("reset.idle_busy", bus.rx_busy, 1'b0);
        evq.delete();

        // table of single frames with two idle bits between them
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].data, vecs[i].stop_bit, vecs[i].par_flip, 2, st);
            expectFrame($sformatf("vec%0d", i), st, vecs[i].exp_data, vecs[i].exp_ferr,
                        vecs[i].exp_perr & PAR_EN);
        end

        // framing error followed by a line stuck low for 40 bits
        applyStimulus(8'h55, 1'b0, 1'b0, 0, st);
        repeat (40 * 16) @(negedge clk16);
        expectFrame("stuck_low", st, 8'hFF, 1'b1, 1'b0);
        checkOutput("stuck_low.busy", bus.rx_busy, 1'b0);
        bus.serial_data = 1'b1;
        repeat (32) @(negedge clk16);
        applyStimulus(8'h8E, 1'b1, 1'b0, 1, st);
        expectFrame("recover", st, 8'h8E, 1'b0, 1'b0);

        // four-cycle glitch: busy rises one cycle after T, then falls back
        bus.serial_data = 1'b0;
        repeat (2) @(negedge clk16);
        checkOutput("glitch.busy_early", bus.rx_busy, 1'b0);
        @(negedge clk16);
        checkOutput("glitch.busy_rise", bus.rx_busy, 1'b1);
        @(negedge clk16);
        bus.serial_data = 1'b1;
        repeat (200) @(negedge clk16);
        checkOutput("glitch.no_strobe", evq.size(), 0);
        checkOutput("glitch.data", bus.paral_data, 8'h8E);
        checkOutput("glitch.busy", bus.rx_busy, 1'b0);
        evq.delete();

        // back-to-back frames with no idle gap
        applyStimulus(8'hA5, 1'b1, 1'b0, 0, st);
        expectFrame("b2b_first", st, 8'hA5, 1'b0, 1'b0);
        applyStimulus(8'h3C, 1'b1, 1'b0, 2, st2);
        expectFrame("b2b_second", st2, 8'h3C, 1'b0, 1'b0);

        // rx_en drops mid-frame: this frame completes, the next is ignored
        fork
            applyStimulus(8'h5A, 1'b1, 1'b0, 1, st);
            begin
                repeat (60) @(negedge clk16);
                bus.rx_en = 1'b0;
            end
        join
        expectFrame("en_drop", st, 8'h5A, 1'b0, 1'b0);
        applyStimulus(8'hC3, 1'b1, 1'b0, 2, st);
        checkOutput("en_off.no_strobe", evq.size(), 0);
        checkOutput("en_off.data", bus.paral_data, 8'h5A);
        evq.delete();
        bus.rx_en = 1'b1;
        applyStimulus(8'hC3, 1'b1, 1'b0, 2, st);
        expectFrame("en_back", st, 8'hC3, 1'b0, 1'b0);

        // framing error, then reset in the middle of the next frame
        applyStimulus(8'h12, 1'b0, 1'b0, 2, st);
        expectFrame("ferr_before_rst", st, 8'hC3, 1'b1, 1'b0);
        bus.serial_data = 1'b0;
        repeat (40) @(negedge clk16);
        checkOutput("midrst.busy_before", bus.rx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.paral_data", bus.paral_data, 8'h00);
        checkOutput("midrst.frame_err",  bus.frame_err,  1'b0);
        checkOutput("midrst.rx_busy",    bus.rx_busy,    1'b0);
        bus.serial_data = 1'b1;
        repeat (3) @(negedge clk16);
        rst_n = 1'b1;
        repeat (40) @(negedge clk16);
        checkOutput("midrst.no_strobe", evq.size(), 0);
        evq.delete();
        applyStimulus(8'h69, 1'b1, 1'b0, 1, st);
        expectFrame("after_rst", st, 8'h69, 1'b0, 1'b0);

        // randomized frames against the reference model
        last_good = 8'h69;
        for (int i = 0; i < 30; i++) begin
            logic [7:0] d;
            logic       sb;
            logic       fl;
            int         gap;
            d   = 8'($urandom);
            sb  = ($urandom_range(0, 4) != 0);
            fl  = 1'($urandom_range(0, 1));
            // a low stop bit needs a high gap or the next start has no edge
            gap = sb ? $urandom_range(0, 3) : $urandom_range(1, 3);
            applyStimulus(d, sb, fl, gap, st);
            model_frame(d, sb, (^d) ^ fl, last_good, eferr, eperr);
            expectFrame($sformatf("rand%0d", i), st, last_good, eferr, eperr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
